// File: rtl/burst_mem_slave_if.sv
// Avalon-MM burst bus between a master and burst_mem_slave.
// Signals:
//   avalon_slave_address       byte address of a burst's first word (master -> slave)
//   avalon_slave_burstcount    burst length in words, 0 treated as 1 (master -> slave)
//   avalon_slave_read/write    command strobes (master -> slave)
//   avalon_slave_writedata     write beat data (master -> slave)
//   avalon_slave_byteenable    per-byte write enables (master -> slave)
//   avalon_slave_waitrequest   command/beat not accepted this cycle (slave -> master)
//   avalon_slave_readdata      read return data (slave -> master)
//   avalon_slave_readdatavalid readdata valid this cycle (slave -> master)
interface burst_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]  avalon_slave_address;
  logic [BURST_WIDTH-1:0] avalon_slave_burstcount;
  logic                   avalon_slave_read;
  logic                   avalon_slave_write;
  logic [31:0]            avalon_slave_writedata;
  logic [3:0]             avalon_slave_byteenable;
  logic                   avalon_slave_waitrequest;
  logic [31:0]            avalon_slave_readdata;
  logic                   avalon_slave_readdatavalid;

  modport master (
    output avalon_slave_address, avalon_slave_burstcount, avalon_slave_read,
           avalon_slave_write, avalon_slave_writedata, avalon_slave_byteenable,
    input  avalon_slave_waitrequest, avalon_slave_readdata, avalon_slave_readdatavalid
  );

  modport slave (
    input  avalon_slave_address, avalon_slave_burstcount, avalon_slave_read,
           avalon_slave_write, avalon_slave_writedata, avalon_slave_byteenable,
    output avalon_slave_waitrequest, avalon_slave_readdata, avalon_slave_readdatavalid
  );
endinterface

// File: rtl/burst_mem_slave.sv
// Avalon-MM burst memory slave backed by a 2^MEM_DEPTH_LOG2 x 32-bit array.
// Writes are accepted one beat per cycle; reads use a two-stage registered array path
// (first readdatavalid two cycles after acceptance, then one word per cycle).
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   bus           burst_mem_slave_if.slave (address, burstcount, read, write, writedata,
//                 byteenable in; waitrequest, readdata, readdatavalid out)
//   protocol_err  sticky protocol-violation flag, cleared only by reset
// Option: define BURST_MEM_SLAVE_STALL_EN to insert one stall cycle in every four while
//   in WRITE or READ (free-running 2-bit counter).
module burst_mem_slave #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BURST_WIDTH    = 7,
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst,
  burst_mem_slave_if.slave bus,
  output logic             protocol_err
);

  localparam int unsigned Depth = 2 ** MEM_DEPTH_LOG2;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef logic [BURST_WIDTH-1:0]    cnt_t;
  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e      state_q, state_d;
  idx_t        wr_idx_q, wr_idx_d;
  idx_t        rd_idx_q, rd_idx_d;
  cnt_t        wr_left_q, wr_left_d;
  cnt_t        rd_issue_q, rd_issue_d;
  cnt_t        rd_ret_q, rd_ret_d;
  logic        err_q, err_d;
  logic        rd_vld1_q;
  logic [31:0] rd_data1_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        stall;
  logic        wait_d;
  logic        mem_we;
  idx_t        mem_widx;
  logic        rd_issue;
  idx_t        cmd_idx;
  cnt_t        bc_eff;
  logic        bc_is_one;

  logic [31:0] mem [Depth];

  // Address bits outside the word index carry no meaning for this array.
  logic unused_addr;
  assign unused_addr = ^{bus.avalon_slave_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2],
                         bus.avalon_slave_address[1:0]};

  assign cmd_idx   = bus.avalon_slave_address[MEM_DEPTH_LOG2+1:2];
  assign bc_eff    = (bus.avalon_slave_burstcount == '0) ? cnt_t'(1)
                                                         : bus.avalon_slave_burstcount;
  assign bc_is_one = (bc_eff == cnt_t'(1));

`ifdef BURST_MEM_SLAVE_STALL_EN
  logic [1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 2'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 2'd1;
    end
  end

  assign stall = (stall_cnt_q == 2'd3) && (state_q != StIdle);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    wr_left_d  = wr_left_q;
    rd_issue_d = rd_issue_q;
    rd_ret_d   = rd_ret_q;
    err_d      = err_q;
    wait_d     = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = wr_idx_q;
    rd_issue   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.avalon_slave_write) begin
          // Write wins over a simultaneous read; the read is dropped and flagged.
          mem_we    = 1'b1;
          mem_widx  = cmd_idx;
          wr_idx_d  = cmd_idx + idx_t'(1);
          wr_left_d = bc_eff - cnt_t'(1);
          if (!bc_is_one) state_d = StWrite;
          if (bus.avalon_slave_read) err_d = 1'b1;
        end else if (bus.avalon_slave_read) begin
          rd_idx_d   = cmd_idx;
          rd_issue_d = bc_eff;
          rd_ret_d   = bc_eff;
          state_d    = StRead;
        end
      end
      StWrite: begin
        wait_d = stall;
        if (bus.avalon_slave_read) err_d = 1'b1;
        // A multi-beat burstcount mid-stream looks like a new burst started too early.
        if (bus.avalon_slave_write && !bc_is_one) err_d = 1'b1;
        if (bus.avalon_slave_write && !stall) begin
          mem_we    = 1'b1;
          wr_idx_d  = wr_idx_q + idx_t'(1);
          wr_left_d = wr_left_q - cnt_t'(1);
          if (wr_left_q == cnt_t'(1)) state_d = StIdle;
        end
      end
      StRead: begin
        wait_d = 1'b1;
        // Holding the index during a stall keeps the returned word order intact.
        if ((rd_issue_q != '0) && !stall) begin
          rd_issue   = 1'b1;
          rd_idx_d   = rd_idx_q + idx_t'(1);
          rd_issue_d = rd_issue_q - cnt_t'(1);
        end
        if (rvalid_q) begin
          rd_ret_d = rd_ret_q - cnt_t'(1);
          if (rd_ret_q == cnt_t'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_left_q  <= '0;
      rd_issue_q <= '0;
      rd_ret_q   <= '0;
      err_q      <= 1'b0;
      rd_vld1_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_left_q  <= wr_left_d;
      rd_issue_q <= rd_issue_d;
      rd_ret_q   <= rd_ret_d;
      err_q      <= err_d;
      rd_vld1_q  <= rd_issue;
      rvalid_q   <= rd_vld1_q;
      if (rd_vld1_q) rdata_q <= rd_data1_q;
    end
  end

  // Array and its registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.avalon_slave_byteenable[b]) begin
          mem[mem_widx][8*b +: 8] <= bus.avalon_slave_writedata[8*b +: 8];
        end
      end
    end
    rd_data1_q <= mem[rd_idx_q];
  end

  assign bus.avalon_slave_waitrequest   = wait_d;
  assign bus.avalon_slave_readdata      = rdata_q;
  assign bus.avalon_slave_readdatavalid = rvalid_q;
  assign protocol_err                   = err_q;

endmodule

// File: tb/tb_burst_mem_slave.sv
module tb_burst_mem_slave;

  logic clk = 1'b0;
  logic rst;
  logic protocol_err;

  always #5 clk = ~clk;

  burst_mem_slave_if #(.ADDR_WIDTH(32), .BURST_WIDTH(7)) bus ();

  burst_mem_slave #(
    .ADDR_WIDTH    (32),
    .BURST_WIDTH   (7),
    .MEM_DEPTH_LOG2(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .protocol_err(protocol_err)
  );

`ifdef BURST_MEM_SLAVE_STALL_EN
  localparam int MaxGap = 1;
  localparam int MaxRun = 3;
`else
  localparam int MaxGap = 0;
  localparam int MaxRun = 1000;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic        first_pending = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          gap = 0;
  int          run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops one expected word per readdatavalid.
  always @(negedge clk) begin
    if (bus.avalon_slave_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdv: readdata 0x%08h with nothing expected (cycle %0d)",
                 bus.avalon_slave_readdata, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check32("readdata", bus.avalon_slave_readdata, mon_exp);
      end
      if (first_pending) begin
`ifndef BURST_MEM_SLAVE_STALL_EN
        check32("first_rdv_latency", 32'(cyc - accept_cyc), 32'd2);
`endif
        first_pending = 1'b0;
        run = 0;
      end else if (gap > MaxGap) begin
        check32("rdv_gap_len", 32'(gap), 32'(MaxGap));
      end
      gap = 0;
      run++;
      if (run > MaxRun) check32("rdv_run_len", 32'(run), 32'(MaxRun));
    end else begin
      run = 0;
      if (!first_pending && exp_q.size() != 0) gap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.avalon_slave_address    = '0;
    bus.avalon_slave_burstcount = 7'd1;
    bus.avalon_slave_read       = 1'b0;
    bus.avalon_slave_write      = 1'b0;
    bus.avalon_slave_writedata  = '0;
    bus.avalon_slave_byteenable = '0;
  endtask

  // Later beats carry a junk address and burstcount 1; the slave must ignore the address.
  task automatic do_write(input logic [31:0] addr, input logic [6:0] bc, input int n,
                          input logic [31:0] d0, input logic [31:0] step,
                          input logic [3:0] be, input logic poke_read);
    logic accepted;
    for (int i = 0; i < n; i++) begin
      bus.avalon_slave_write      = 1'b1;
      bus.avalon_slave_read       = (i > 0) ? poke_read : 1'b0;
      bus.avalon_slave_address    = (i == 0) ? addr : 32'hDEAD_0A50;
      bus.avalon_slave_burstcount = (i == 0) ? bc : 7'd1;
      bus.avalon_slave_writedata  = d0 + 32'(i) * step;
      bus.avalon_slave_byteenable = be;
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        @(negedge clk);
        accepted = (bus.avalon_slave_waitrequest === 1'b0);
        tick();
      end
      if (!accepted) check32("write_accept_timeout", 32'd0, 32'd1);
    end
    idle_bus();
  endtask

  task automatic do_read(input logic [31:0] addr, input int n,
                         input logic [31:0] d0, input logic [31:0] step);
    for (int i = 0; i < n; i++) exp_q.push_back(d0 + 32'(i) * step);
    bus.avalon_slave_read       = 1'b1;
    bus.avalon_slave_address    = addr;
    bus.avalon_slave_burstcount = 7'(n);
    @(negedge clk);
    check32("read_cmd_waitrequest", 32'(bus.avalon_slave_waitrequest), 32'd0);
    tick();
    idle_bus();
    accept_cyc    = cyc;
    first_pending = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check32("read_timeout_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      first_pending = 1'b0;
    end else begin
      check32("idle_after_read", 32'(bus.avalon_slave_waitrequest), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int count;
    idle_bus();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check32("rst_waitrequest", 32'(bus.avalon_slave_waitrequest), 32'd0);
    check32("rst_readdatavalid", 32'(bus.avalon_slave_readdatavalid), 32'd0);
    check32("rst_readdata", bus.avalon_slave_readdata, 32'd0);
    check32("rst_protocol_err", 32'(protocol_err), 32'd0);

    // 16-beat write then 16-beat read at 0x100.
    do_write(32'h100, 7'd16, 16, 32'hA0, 32'd1, 4'hF, 1'b0);
    do_read(32'h100, 16, 32'hA0, 32'd1);
    check32("no_err_after_bursts", 32'(protocol_err), 32'd0);

    // Byteenable merge.
    do_write(32'h200, 7'd1, 1, 32'h1234_5678, 32'd0, 4'hF, 1'b0);
    do_write(32'h200, 7'd1, 1, 32'hFFFF_FFFF, 32'd0, 4'b0101, 1'b0);
    do_read(32'h200, 1, 32'h12FF_56FF, 32'd0);

    // Wrap from the last word to index 0; upper and low address bits ignored.
    do_write(32'hFFC, 7'd4, 4, 32'h11, 32'h11, 4'hF, 1'b0);
    do_read(32'hFFC, 1, 32'h11, 32'd0);
    do_read(32'h000, 3, 32'h22, 32'h11);
    do_read(32'h1003, 1, 32'h22, 32'd0);

    // Burstcount 0 behaves as a single beat.
    do_write(32'h300, 7'd0, 1, 32'h55, 32'd0, 4'hF, 1'b0);
    do_write(32'h310, 7'd1, 1, 32'h66, 32'd0, 4'hF, 1'b0);
    do_read(32'h310, 1, 32'h66, 32'd0);
    do_read(32'h300, 1, 32'h55, 32'd0);
    check32("no_err_bc0", 32'(protocol_err), 32'd0);

    // Reset on the 5th readdatavalid of a 16-beat read.
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + 32'(i));
    bus.avalon_slave_read       = 1'b1;
    bus.avalon_slave_address    = 32'h100;
    bus.avalon_slave_burstcount = 7'd16;
    tick();
    idle_bus();
    accept_cyc    = cyc;
    first_pending = 1'b1;
    count = 0;
    for (int t = 0; t < 60 && count < 5; t++) begin
      tick();
      if (bus.avalon_slave_readdatavalid === 1'b1) count++;
    end
    check32("rdv_before_reset", 32'(count), 32'd5);
    pulse_reset();
    check32("abort_readdatavalid", 32'(bus.avalon_slave_readdatavalid), 32'd0);
    check32("abort_waitrequest", 32'(bus.avalon_slave_waitrequest), 32'd0);
    check32("abort_readdata", bus.avalon_slave_readdata, 32'd0);
    repeat (20) tick();
    check32("abort_exp_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    first_pending = 1'b0;
    do_read(32'h100, 2, 32'hA0, 32'd1);

    // Read and write together in IDLE.
    bus.avalon_slave_read       = 1'b1;
    bus.avalon_slave_write      = 1'b1;
    bus.avalon_slave_address    = 32'h400;
    bus.avalon_slave_burstcount = 7'd1;
    bus.avalon_slave_writedata  = 32'h77;
    bus.avalon_slave_byteenable = 4'hF;
    tick();
    idle_bus();
    repeat (6) tick();
    check32("rw_protocol_err", 32'(protocol_err), 32'd1);
    do_read(32'h400, 1, 32'h77, 32'd0);
    check32("rw_err_sticky", 32'(protocol_err), 32'd1);
    pulse_reset();
    check32("err_cleared_by_reset", 32'(protocol_err), 32'd0);

    // Read strobe during a write burst.
    do_write(32'h500, 7'd2, 2, 32'h501, 32'd1, 4'hF, 1'b1);
    repeat (4) tick();
    check32("read_in_write_err", 32'(protocol_err), 32'd1);
    do_read(32'h500, 2, 32'h501, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
